// File: rtl/fu_result_queue_pkg.sv
// Shared types for the FU result queue: the result record carried from the FUs to the ROB.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

package fu_result_queue_pkg;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [`ROB_IDX_SIZE-1:0] rob_index;
        logic [`GPR_SIZE-1:0]     value;
        logic                     set_nzcv;
        nzcv_t                    nzcv;
        logic                     condition;
    } fu_result_t;

endpackage

// File: rtl/result_fifo.sv
// Ring-buffer FIFO of arbitrary record type T with synchronous flush and occupancy count.
module result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullLevel = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FullLevel);
    assign empty_o = (count_q == '0);

    // A push into a full queue only lands if the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fu_result_queue.sv
// Result buffer between the FUs and the ROB: in-order FIFO, RS back-pressure, sticky overflow.
// Optional same-cycle bypass into the ROB when empty is enabled by `FU_RESULT_BYPASS_EN.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

module fu_result_queue
    import fu_result_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_MARGIN = 1
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic                     in_flush,
    input  logic                     in_fu_done,
    input  logic [`ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
    input  logic [`GPR_SIZE-1:0]     in_fu_value,
    input  logic                     in_fu_set_nzcv,
    input  nzcv_t                    in_fu_nzcv,
    input  logic                     in_fu_condition,
    output logic                     out_rs_stall,
    input  logic                     in_rob_ready,
    output logic                     out_rob_valid,
    output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [`GPR_SIZE-1:0]     out_rob_value,
    output logic                     out_rob_set_nzcv,
    output nzcv_t                    out_rob_nzcv,
    output logic                     out_rob_condition,
    output logic                     out_overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] StallLevel = CW'(DEPTH - STALL_MARGIN);

    fu_result_t    fu_in, fifo_head, head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, pop, bypass, fifo_push;
    logic          overflow_q;

    assign fu_in = '{
        rob_index: in_fu_dst_rob_index,
        value:     in_fu_value,
        set_nzcv:  in_fu_set_nzcv,
        nzcv:      in_fu_nzcv,
        condition: in_fu_condition
    };

`ifdef FU_RESULT_BYPASS_EN
    assign bypass = empty & in_fu_done & in_rob_ready & ~in_flush;
`else
    assign bypass = 1'b0;
`endif

    assign push      = in_fu_done & ~in_flush;
    assign pop       = ~empty & in_rob_ready & ~in_flush;
    assign fifo_push = push & ~bypass;

    result_fifo #(
        .DEPTH (DEPTH),
        .T     (fu_result_t)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_ni  (in_rst_n),
        .flush_i (in_flush),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .wdata_i (fu_in),
        .rdata_o (fifo_head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            overflow_q <= 1'b0;
        end else if (full & push & ~pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_rs_stall = (count >= StallLevel) | in_flush;
    assign out_overflow = overflow_q;

    // Data lines read as zero whenever nothing valid is presented.
    always_comb begin
        head = '0;
        if (bypass) begin
            head = fu_in;
        end else if (!empty) begin
            head = fifo_head;
        end
        out_rob_valid         = ~empty | bypass;
        out_rob_dst_rob_index = head.rob_index;
        out_rob_value         = head.value;
        out_rob_set_nzcv      = head.set_nzcv;
        out_rob_nzcv          = head.nzcv;
        out_rob_condition     = head.condition;
    end

endmodule

// File: tb/tb_fu_result_queue.sv
// Directed, table-driven bench for fu_result_queue (DEPTH=4, STALL_MARGIN=1).
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

module tb_fu_result_queue;
    import fu_result_queue_pkg::*;

    localparam int RW = `ROB_IDX_SIZE;
    localparam int GW = `GPR_SIZE;

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic          in_flush;
    logic          in_fu_done;
    logic [RW-1:0] in_fu_dst_rob_index;
    logic [GW-1:0] in_fu_value;
    logic          in_fu_set_nzcv;
    nzcv_t         in_fu_nzcv;
    logic          in_fu_condition;
    logic          out_rs_stall;
    logic          in_rob_ready;
    logic          out_rob_valid;
    logic [RW-1:0] out_rob_dst_rob_index;
    logic [GW-1:0] out_rob_value;
    logic          out_rob_set_nzcv;
    nzcv_t         out_rob_nzcv;
    logic          out_rob_condition;
    logic          out_overflow;

    fu_result_queue #(
        .DEPTH        (4),
        .STALL_MARGIN (1)
    ) dut (
        .in_clk                (in_clk),
        .in_rst_n              (in_rst_n),
        .in_flush              (in_flush),
        .in_fu_done            (in_fu_done),
        .in_fu_dst_rob_index   (in_fu_dst_rob_index),
        .in_fu_value           (in_fu_value),
        .in_fu_set_nzcv        (in_fu_set_nzcv),
        .in_fu_nzcv            (in_fu_nzcv),
        .in_fu_condition       (in_fu_condition),
        .out_rs_stall          (out_rs_stall),
        .in_rob_ready          (in_rob_ready),
        .out_rob_valid         (out_rob_valid),
        .out_rob_dst_rob_index (out_rob_dst_rob_index),
        .out_rob_value         (out_rob_value),
        .out_rob_set_nzcv      (out_rob_set_nzcv),
        .out_rob_nzcv          (out_rob_nzcv),
        .out_rob_condition     (out_rob_condition),
        .out_overflow          (out_overflow)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic          done;
        logic [RW-1:0] idx;
        logic [GW-1:0] val;
        logic          set;
        nzcv_t         nzcv;
        logic          cond;
        logic          ready;
        logic          ev;
        logic [RW-1:0] eidx;
        logic [GW-1:0] eval;
        logic          eset;
        nzcv_t         enzcv;
        logic          econd;
        logic          estall;
        int            ecount;
        logic          eovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input int idx, input logic [GW-1:0] val, input logic set,
                       input int nz, input logic cond, input logic rdy, input logic ev,
                       input int eidx, input logic [GW-1:0] eval, input logic eset, input int enz,
                       input logic econd, input logic estall, input int ecount, input logic eovf);
        vec_t v;
        v.done = d;      v.idx = RW'(idx);     v.val = val;     v.set = set;
        v.nzcv = 4'(nz); v.cond = cond;        v.ready = rdy;
        v.ev = ev;       v.eidx = RW'(eidx);   v.eval = eval;   v.eset = eset;
        v.enzcv = 4'(enz); v.econd = econd;    v.estall = estall;
        v.ecount = ecount; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic d, input int idx, input logic [GW-1:0] val,
                         input logic rdy, input logic fl);
        in_fu_done          = d;
        in_fu_dst_rob_index = RW'(idx);
        in_fu_value         = val;
        in_fu_set_nzcv      = 1'b0;
        in_fu_nzcv          = 4'd0;
        in_fu_condition     = 1'b0;
        in_rob_ready        = rdy;
        in_flush            = fl;
    endtask

    task automatic tick();
        @(posedge in_clk);
        @(negedge in_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_rst_n = 1'b0;
        drive(1'b0, 0, '0, 1'b0, 1'b0);
        @(negedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        // In-order drain: A=(3,10), B=(5,-7), C=(1,0).
        add(1, 3, 10, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0);
        add(1, 5, -7, 1, 4'b1000, 1, 0,   1, 3, 10, 0, 4'b0000, 0,   0, 1, 0);
        add(1, 1, 0, 1, 4'b0100, 0, 0,    1, 3, 10, 0, 4'b0000, 0,   0, 2, 0);
        add(0, 0, 0, 0, 0, 0, 1,          1, 3, 10, 0, 4'b0000, 0,   1, 3, 0);
        add(0, 0, 0, 0, 0, 0, 1,          1, 5, -7, 1, 4'b1000, 1,   0, 2, 0);
        add(0, 0, 0, 0, 0, 0, 1,          1, 1, 0, 1, 4'b0100, 0,    0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,          0, 0, 0);
        // Full: D_k = (8+k, 100+k, nzcv=k, cond=k[0]); D5 is dropped.
        add(1, 8, 100, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,          0, 0, 0);
        add(1, 9, 101, 0, 1, 1, 0,        1, 8, 100, 0, 0, 0,        0, 1, 0);
        add(1, 10, 102, 0, 2, 0, 0,       1, 8, 100, 0, 0, 0,        0, 2, 0);
        add(1, 11, 103, 0, 3, 1, 0,       1, 8, 100, 0, 0, 0,        1, 3, 0);
        add(1, 12, 104, 0, 4, 0, 1,       1, 8, 100, 0, 0, 0,        1, 4, 0);
        add(1, 13, 105, 0, 5, 1, 0,       1, 9, 101, 0, 1, 1,        1, 4, 0);
        add(0, 0, 0, 0, 0, 0, 1,          1, 9, 101, 0, 1, 1,        1, 4, 1);
        add(0, 0, 0, 0, 0, 0, 1,          1, 10, 102, 0, 2, 0,       1, 3, 1);
        add(0, 0, 0, 0, 0, 0, 1,          1, 11, 103, 0, 3, 1,       0, 2, 1);
        add(0, 0, 0, 0, 0, 0, 1,          1, 12, 104, 0, 4, 0,       0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,          0, 0, 1);

        foreach (vecs[i]) begin
            in_fu_done          = vecs[i].done;
            in_fu_dst_rob_index = vecs[i].idx;
            in_fu_value         = vecs[i].val;
            in_fu_set_nzcv      = vecs[i].set;
            in_fu_nzcv          = vecs[i].nzcv;
            in_fu_condition     = vecs[i].cond;
            in_rob_ready        = vecs[i].ready;
            in_flush            = 1'b0;
            #1;
            check($sformatf("v%0d valid", i), 64'(out_rob_valid), 64'(vecs[i].ev));
            check($sformatf("v%0d index", i), 64'(out_rob_dst_rob_index), 64'(vecs[i].eidx));
            check($sformatf("v%0d value", i), 64'(out_rob_value), 64'(vecs[i].eval));
            check($sformatf("v%0d set_nzcv", i), 64'(out_rob_set_nzcv), 64'(vecs[i].eset));
            check($sformatf("v%0d nzcv", i), 64'(out_rob_nzcv), 64'(vecs[i].enzcv));
            check($sformatf("v%0d condition", i), 64'(out_rob_condition), 64'(vecs[i].econd));
            check($sformatf("v%0d stall", i), 64'(out_rs_stall), 64'(vecs[i].estall));
            check($sformatf("v%0d count", i), 64'(dut.count), 64'(vecs[i].ecount));
            check($sformatf("v%0d overflow", i), 64'(out_overflow), 64'(vecs[i].eovf));
            tick();
        end

        // Reset mid-stream with two entries queued (overflow is still set from above).
        drive(1'b1, 2, 50, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4, 51, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 1'b0);
        #1;
        check("rst pre count", 64'(dut.count), 64'd2);
        #1;
        in_rst_n = 1'b0;
        #1;
        check("rst valid", 64'(out_rob_valid), 64'd0);
        check("rst index", 64'(out_rob_dst_rob_index), 64'd0);
        check("rst value", 64'(out_rob_value), 64'd0);
        check("rst stall", 64'(out_rs_stall), 64'd0);
        check("rst overflow", 64'(out_overflow), 64'd0);
        check("rst count", 64'(dut.count), 64'd0);
        tick();
        in_rst_n = 1'b1;
        in_rob_ready = 1'b1;
        #1;
        check("rst rel valid", 64'(out_rob_valid), 64'd0);
        tick();
        check("rst rel valid2", 64'(out_rob_valid), 64'd0);
        check("rst rel overflow", 64'(out_overflow), 64'd0);

        // Wrap-around: ten back-to-back push/pop pairs.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16 + i, GW'(200 + i), 1'b1, 1'b0);
            #1;
`ifdef FU_RESULT_BYPASS_EN
            check($sformatf("wrap%0d valid", i), 64'(out_rob_valid), 64'd1);
            check($sformatf("wrap%0d index", i), 64'(out_rob_dst_rob_index), 64'(16 + i));
            check($sformatf("wrap%0d value", i), 64'(out_rob_value), 64'(200 + i));
            check($sformatf("wrap%0d count", i), 64'(dut.count), 64'd0);
`else
            check($sformatf("wrap%0d valid", i), 64'(out_rob_valid), 64'(i != 0));
            check($sformatf("wrap%0d index", i), 64'(out_rob_dst_rob_index),
                  (i == 0) ? 64'd0 : 64'(15 + i));
            check($sformatf("wrap%0d value", i), 64'(out_rob_value),
                  (i == 0) ? 64'd0 : 64'(199 + i));
            check($sformatf("wrap%0d count", i), 64'(dut.count), 64'(i != 0));
`endif
            tick();
        end
        drive(1'b0, 0, '0, 1'b1, 1'b0);
        #1;
`ifdef FU_RESULT_BYPASS_EN
        check("wrap tail valid", 64'(out_rob_valid), 64'd0);
`else
        check("wrap tail valid", 64'(out_rob_valid), 64'd1);
        check("wrap tail index", 64'(out_rob_dst_rob_index), 64'd25);
        check("wrap tail value", 64'(out_rob_value), 64'd209);
`endif
        tick();
        check("wrap drained", 64'(out_rob_valid), 64'd0);

        // Flush with three queued and a concurrent completion.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 26 + i, GW'(300 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 29, 399, 1'b1, 1'b1);
        #1;
        check("flush stall", 64'(out_rs_stall), 64'd1);
        check("flush pre count", 64'(dut.count), 64'd3);
        tick();
        drive(1'b0, 0, '0, 1'b1, 1'b0);
        #1;
        check("flush count", 64'(dut.count), 64'd0);
        check("flush valid", 64'(out_rob_valid), 64'd0);
        check("flush value", 64'(out_rob_value), 64'd0);
        check("flush stall after", 64'(out_rs_stall), 64'd0);
        tick();
        check("flush valid2", 64'(out_rob_valid), 64'd0);
        drive(1'b1, 30, 400, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, '0, 1'b0, 1'b0);
        #1;
        check("post flush index", 64'(out_rob_dst_rob_index), 64'd30);
        check("post flush value", 64'(out_rob_value), 64'd400);
        check("post flush count", 64'(dut.count), 64'd1);
        in_rob_ready = 1'b1;
        tick();
        check("post flush drained", 64'(out_rob_valid), 64'd0);

        // Bypass stimulus: empty queue, completion with ROB ready.
        drive(1'b1, 7, 42, 1'b1, 1'b0);
        #1;
`ifdef FU_RESULT_BYPASS_EN
        check("byp valid", 64'(out_rob_valid), 64'd1);
        check("byp index", 64'(out_rob_dst_rob_index), 64'd7);
        check("byp value", 64'(out_rob_value), 64'd42);
`else
        check("byp valid", 64'(out_rob_valid), 64'd0);
`endif
        tick();
        drive(1'b0, 0, '0, 1'b0, 1'b0);
        #1;
`ifdef FU_RESULT_BYPASS_EN
        check("byp next valid", 64'(out_rob_valid), 64'd0);
        check("byp count", 64'(dut.count), 64'd0);
`else
        check("byp next valid", 64'(out_rob_valid), 64'd1);
        check("byp next index", 64'(out_rob_dst_rob_index), 64'd7);
        check("byp next value", 64'(out_rob_value), 64'd42);
        check("byp count", 64'(dut.count), 64'd1);
`endif
        in_rob_ready = 1'b1;
        tick();
        check("byp drained", 64'(out_rob_valid), 64'd0);
        check("final overflow", 64'(out_overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
